// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave that snapshots a fabric word for software to read back, with a
// status word (fresh, overflow, armed, capture count) and a control word.
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR     = 32'h0108E300,
    parameter logic [31:0] C_HIGHADDR     = 32'h0108E3FF,
    parameter int          C_OPB_AWIDTH   = 32,
    parameter int          C_OPB_DWIDTH   = 32,
    parameter              C_FAMILY       = "virtex5",
    parameter int          C_ARM_ON_RESET = 1
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic                    Sl_xferAck,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid,
    output logic [1:0]              fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic ARM_INIT = (C_ARM_ON_RESET != 0);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] snapshot;
    logic        fresh;
    logic        overflow;
    logic        armed;
    logic [15:0] count;
    logic [31:0] rd_word;
    logic        hit;
    logic [1:0]  offset;
    logic        take;
    logic        data_rd;
    logic        ctrl_wr;
    logic        clr;
    logic        capture;
    logic        unused_bits;

    assign unused_bits = ^{OPB_BE, OPB_seqAddr, OPB_DBus[0:28], |C_FAMILY};

    // Handshake: a transfer is offered while OPB_select is high with an
    // address in the window; it is accepted at the first rising edge seen in
    // IDLE and acknowledged by a single Sl_xferAck cycle (ACK), followed by a
    // mandatory GAP cycle. A still-high select after GAP starts a new transfer.
    assign hit     = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign offset  = OPB_ABus[28:29];
    assign take    = (state == IDLE) && hit;
    assign data_rd = take && OPB_RNW && (offset == 2'd0);
    assign ctrl_wr = take && !OPB_RNW && (offset == 2'd2);
    assign clr     = ctrl_wr && OPB_DBus[30];
    assign capture = user_valid && armed;

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign Sl_xferAck = (state == ACK);
    assign fsm_state  = state;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hit) state_nxt = ACK;
            ACK:     state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_word = 32'd0;
        case (offset)
            2'd0:    rd_word = snapshot;
            2'd1:    rd_word = {count, 13'd0, armed, overflow, fresh};
            default: rd_word = 32'd0;
        endcase
    end

    // Read data comes from the pre-edge register values, so a coincident
    // capture is seen by the next read, not this one.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            Sl_DBus <= '0;
        end else if (take && OPB_RNW) begin
            Sl_DBus <= rd_word;
        end else begin
            Sl_DBus <= '0;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            snapshot <= 32'd0;
            fresh    <= 1'b0;
            overflow <= 1'b0;
            count    <= 16'd0;
            armed    <= ARM_INIT;
        end else begin
            if (capture) begin
                snapshot <= user_data_in;
            end
            // Clear has priority over a coincident capture for the bookkeeping.
            if (clr) begin
                fresh    <= 1'b0;
                overflow <= 1'b0;
                count    <= 16'd0;
            end else if (capture) begin
                fresh <= 1'b1;
                count <= count + 16'd1;
                if (fresh && !data_rd) begin
                    overflow <= 1'b1;
                end
            end else if (data_rd) begin
                fresh <= 1'b0;
            end
            if (ctrl_wr && OPB_DBus[29]) begin
                armed <= 1'b0;
            end else if (ctrl_wr && OPB_DBus[31]) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Bench for the simulink2ppc snapshot register: directed vector table,
// randomized traffic against a transaction-level model, and corner sequences.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] BASE   = 32'h0108E300;
    localparam logic [31:0] HIGH   = 32'h0108E3FF;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'd4;
    localparam logic [31:0] A_CTRL = BASE + 32'd8;
    localparam logic [31:0] A_RSV  = BASE + 32'd12;
    localparam int K_BUS = 0;
    localparam int K_CAP = 1;

    logic        clk;
    logic        rst_n;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus;
    logic        rnw;
    logic        select;
    logic        seq_addr;
    logic [0:31] sl_dbus;
    logic        sl_err_ack;
    logic        sl_retry;
    logic        sl_tout_sup;
    logic        sl_xfer_ack;
    logic [31:0] user_data_in;
    logic        user_valid;
    logic [1:0]  fsm_state;

    int n_vec;
    int n_bad;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic        rnw;
        logic [31:0] wdata;
        logic        cap;
        logic [31:0] cap_data;
        logic        exp_ack;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[$];

    // Transaction-level model state
    logic [31:0] m_snap;
    logic        m_fresh;
    logic        m_ovf;
    logic        m_armed;
    int          m_count;

    opb_register_simulink2ppc_snap dut (
        .OPB_Clk      (clk),
        .OPB_Rst_n    (rst_n),
        .OPB_ABus     (abus),
        .OPB_BE       (be),
        .OPB_DBus     (dbus),
        .OPB_RNW      (rnw),
        .OPB_select   (select),
        .OPB_seqAddr  (seq_addr),
        .Sl_DBus      (sl_dbus),
        .Sl_errAck    (sl_err_ack),
        .Sl_retry     (sl_retry),
        .Sl_toutSup   (sl_tout_sup),
        .Sl_xferAck   (sl_xfer_ack),
        .user_data_in (user_data_in),
        .user_valid   (user_valid),
        .fsm_state    (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_snap  = 32'd0;
        m_fresh = 1'b0;
        m_ovf   = 1'b0;
        m_armed = 1'b1;
        m_count = 0;
    endfunction

    function automatic void model_step(input vec_t v, output logic e_ack, output logic [31:0] e_data);
        logic hit;
        logic is_data_rd;
        logic is_ctrl;
        logic cap_now;
        int   off;
        hit    = (v.kind == K_BUS) && (v.addr >= BASE) && (v.addr <= HIGH);
        off    = int'(v.addr[3:2]);
        e_ack  = hit;
        e_data = 32'd0;
        if (hit && v.rnw) begin
            if (off == 0) e_data = m_snap;
            else if (off == 1) e_data = (m_count << 16) | (32'(m_armed) << 2) | (32'(m_ovf) << 1) | 32'(m_fresh);
        end
        cap_now    = v.cap && m_armed;
        is_data_rd = hit && v.rnw && (off == 0);
        is_ctrl    = hit && !v.rnw && (off == 2);
        if (cap_now) begin
            m_ovf   = m_ovf | (m_fresh & !is_data_rd);
            m_snap  = v.cap_data;
            m_count = (m_count + 1) % 65536;
            m_fresh = 1'b1;
        end else if (is_data_rd) begin
            m_fresh = 1'b0;
        end
        if (is_ctrl) begin
            if (v.wdata[2]) m_armed = 1'b0;
            else if (v.wdata[0]) m_armed = 1'b1;
            if (v.wdata[1]) begin
                m_count = 0;
                m_fresh = 1'b0;
                m_ovf   = 1'b0;
            end
        end
    endfunction

    function automatic vec_t mk_bus(logic [31:0] addr, logic r, logic [31:0] wd, logic cap,
                                    logic [31:0] cd, logic ea, logic [31:0] ed);
        vec_t v;
        v.kind = K_BUS; v.addr = addr; v.rnw = r; v.wdata = wd;
        v.cap = cap; v.cap_data = cd; v.exp_ack = ea; v.exp_data = ed;
        return v;
    endfunction

    function automatic vec_t mk_cap(logic [31:0] cd);
        vec_t v;
        v = mk_bus(32'd0, 1'b0, 32'd0, 1'b1, cd, 1'b0, 32'd0);
        v.kind = K_CAP;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(input vec_t v, output int n_ack, output logic [31:0] data,
                          output int lat, output logic stray);
        n_ack = 0; data = 32'd0; lat = 0; stray = 1'b0;
        if (v.kind == K_CAP) begin
            @(negedge clk);
            user_valid = 1'b1; user_data_in = v.cap_data;
            @(negedge clk);
            user_valid = 1'b0;
        end else begin
            @(negedge clk);
            abus = v.addr; rnw = v.rnw; dbus = v.wdata; select = 1'b1;
            user_valid = v.cap; user_data_in = v.cap_data;
            for (int i = 1; i <= 4; i++) begin
                @(negedge clk);
                user_valid = 1'b0;
                if (sl_xfer_ack) begin
                    n_ack++;
                    if (n_ack == 1) begin
                        data = sl_dbus;
                        lat  = i;
                    end
                    select = 1'b0;
                end else if (sl_dbus != 32'd0) begin
                    stray = 1'b1;
                end
            end
            select = 1'b0;
        end
    endtask

    task automatic apply_check(input string tag, input vec_t v, input logic e_ack, input logic [31:0] e_data);
        int          n_ack;
        logic [31:0] data;
        int          lat;
        logic        stray;
        run_op(v, n_ack, data, lat, stray);
        if (v.kind == K_BUS) begin
            check({tag, "_acks"}, 32'(n_ack), e_ack ? 32'd1 : 32'd0);
            check({tag, "_data"}, data, e_data);
            check({tag, "_idle_bus"}, 32'(stray), 32'd0);
            if (e_ack) check({tag, "_latency"}, 32'(lat), 32'd1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic        e_ack;
        logic [31:0] e_data;
        logic [5:0]  seen;
        logic [31:0] held_data;
        logic [2:0]  ctl_pick [6];
        vec_t        v;

        n_vec = 0; n_bad = 0;
        rst_n = 1'b0; abus = '0; be = '0; dbus = '0; rnw = 1'b0; select = 1'b0;
        seq_addr = 1'b0; user_data_in = '0; user_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_ack", 32'(sl_xfer_ack), 32'd0);
        check("reset_dbus", sl_dbus, 32'd0);
        check("reset_state", 32'(fsm_state), 32'd0);
        rst_n = 1'b1;

        // Directed table
        tbl.push_back(mk_bus(A_STAT, 1, 0, 0, 0, 1, 32'h00000004));
        tbl.push_back(mk_cap(32'hDEADBEEF));
        tbl.push_back(mk_bus(A_DATA, 1, 0, 0, 0, 1, 32'hDEADBEEF));
        tbl.push_back(mk_bus(A_STAT, 1, 0, 0, 0, 1, 32'h00010004));
        tbl.push_back(mk_bus(A_CTRL, 0, 32'h2, 0, 0, 1, 32'h0));
        tbl.push_back(mk_cap(32'h11));
        tbl.push_back(mk_cap(32'h22));
        tbl.push_back(mk_bus(A_STAT, 1, 0, 0, 0, 1, 32'h00020007));
        tbl.push_back(mk_bus(A_DATA, 1, 0, 0, 0, 1, 32'h00000022));
        tbl.push_back(mk_bus(A_CTRL, 0, 32'h2, 0, 0, 1, 32'h0));
        tbl.push_back(mk_bus(A_STAT, 1, 0, 0, 0, 1, 32'h00000004));
        tbl.push_back(mk_bus(A_CTRL, 0, 32'h4, 0, 0, 1, 32'h0));
        tbl.push_back(mk_cap(32'h55));
        tbl.push_back(mk_bus(A_DATA, 1, 0, 0, 0, 1, 32'h00000022));
        tbl.push_back(mk_bus(A_STAT, 1, 0, 0, 0, 1, 32'h00000000));
        tbl.push_back(mk_bus(A_CTRL, 1, 0, 0, 0, 1, 32'h0));
        tbl.push_back(mk_bus(A_RSV, 1, 0, 0, 0, 1, 32'h0));
        tbl.push_back(mk_bus(A_DATA, 0, 32'hFFFFFFFF, 0, 0, 1, 32'h0));
        tbl.push_back(mk_bus(A_RSV, 0, 32'hFFFFFFFF, 0, 0, 1, 32'h0));
        tbl.push_back(mk_bus(A_DATA, 1, 0, 0, 0, 1, 32'h00000022));
        tbl.push_back(mk_bus(A_CTRL, 0, 32'h5, 0, 0, 1, 32'h0));
        tbl.push_back(mk_bus(A_STAT, 1, 0, 0, 0, 1, 32'h00000000));
        tbl.push_back(mk_bus(A_CTRL, 0, 32'h1, 0, 0, 1, 32'h0));
        tbl.push_back(mk_bus(A_STAT, 1, 0, 0, 0, 1, 32'h00000004));
        tbl.push_back(mk_cap(32'h77));
        tbl.push_back(mk_bus(A_DATA, 1, 0, 1, 32'h99, 1, 32'h00000077));
        tbl.push_back(mk_bus(A_STAT, 1, 0, 0, 0, 1, 32'h00020005));
        tbl.push_back(mk_bus(A_DATA, 1, 0, 0, 0, 1, 32'h00000099));
        tbl.push_back(mk_bus(A_STAT, 1, 0, 0, 0, 1, 32'h00020004));
        tbl.push_back(mk_bus(A_CTRL, 0, 32'h2, 1, 32'hAB, 1, 32'h0));
        tbl.push_back(mk_bus(A_STAT, 1, 0, 0, 0, 1, 32'h00000004));
        tbl.push_back(mk_bus(A_DATA, 1, 0, 0, 0, 1, 32'h000000AB));
        tbl.push_back(mk_bus(A_CTRL, 0, 32'h4, 1, 32'hCD, 1, 32'h0));
        tbl.push_back(mk_bus(A_STAT, 1, 0, 0, 0, 1, 32'h00010001));
        tbl.push_back(mk_bus(A_DATA, 1, 0, 0, 0, 1, 32'h000000CD));
        tbl.push_back(mk_bus(A_CTRL, 0, 32'h1, 0, 0, 1, 32'h0));
        tbl.push_back(mk_bus(32'h0108E400, 1, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk_bus(32'h0108E2FC, 0, 32'h2, 0, 0, 0, 32'h0));
        tbl.push_back(mk_bus(32'h0108E3FC, 1, 0, 0, 0, 1, 32'h0));
        tbl.push_back(mk_bus(32'h0108E3F0, 1, 0, 0, 0, 1, 32'h000000CD));

        for (int i = 0; i < tbl.size(); i++) begin
            model_step(tbl[i], e_ack, e_data);
            apply_check($sformatf("vec%0d", i), tbl[i], tbl[i].exp_ack, tbl[i].exp_data);
        end

        // Held select: re-triggers after the GAP cycle
        @(negedge clk);
        abus = A_STAT; rnw = 1'b1; select = 1'b1;
        seen = '0; held_data = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen[5-i] = sl_xfer_ack;
            if (i == 3) held_data = sl_dbus;
        end
        select = 1'b0;
        check("held_select_acks", 32'(seen), 32'b100100);
        check("held_select_data", held_data, 32'h00010004);

        // Randomized traffic against the model
        ctl_pick = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [31:0] addr;
            r = $urandom_range(0, 9);
            if (r < 3) begin
                v = mk_cap($urandom);
            end else begin
                if ($urandom_range(0, 99) < 85) addr = BASE + (32'($urandom_range(0, 63)) << 2);
                else if ($urandom_range(0, 1) == 0) addr = 32'h0108E400 + (32'($urandom_range(0, 255)) << 2);
                else addr = BASE - (32'($urandom_range(1, 64)) << 2);
                v = mk_bus(addr, $urandom_range(0, 9) < 7, ($urandom & 32'hFFFFFFF8) | 32'(ctl_pick[$urandom_range(0, 5)]),
                           $urandom_range(0, 3) == 0, $urandom, 0, 0);
            end
            model_step(v, e_ack, e_data);
            apply_check($sformatf("rnd%0d", i), v, e_ack, e_data);
        end

        // Count wrap: arm + clear, then 65535 back-to-back captures, then one more
        v = mk_bus(A_CTRL, 0, 32'h3, 0, 0, 1, 0);
        model_step(v, e_ack, e_data);
        apply_check("wrap_ctrl", v, 1'b1, 32'h0);
        @(negedge clk);
        user_valid = 1'b1; user_data_in = 32'h12345678;
        repeat (65535) @(negedge clk);
        user_valid = 1'b0;
        for (int i = 0; i < 65535; i++) model_step(mk_cap(32'h12345678), e_ack, e_data);
        v = mk_bus(A_STAT, 1, 0, 0, 0, 1, 0);
        model_step(v, e_ack, e_data);
        apply_check("wrap_ffff", v, 1'b1, 32'hFFFF0007);
        v = mk_cap(32'h0BADF00D);
        model_step(v, e_ack, e_data);
        apply_check("wrap_cap", v, 1'b0, 32'h0);
        v = mk_bus(A_STAT, 1, 0, 0, 0, 1, 0);
        model_step(v, e_ack, e_data);
        apply_check("wrap_zero", v, 1'b1, 32'h00000007);
        v = mk_bus(A_DATA, 1, 0, 0, 0, 1, 0);
        model_step(v, e_ack, e_data);
        apply_check("wrap_data", v, 1'b1, 32'h0BADF00D);

        // Reset asserted during the ACK cycle
        v = mk_bus(A_CTRL, 0, 32'h4, 0, 0, 1, 0);
        model_step(v, e_ack, e_data);
        apply_check("pre_rst_disarm", v, 1'b1, 32'h0);
        @(negedge clk);
        abus = A_STAT; rnw = 1'b1; select = 1'b1;
        @(negedge clk);
        check("pre_rst_ack", 32'(sl_xfer_ack), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_drop_ack", 32'(sl_xfer_ack), 32'd0);
        check("rst_drop_dbus", sl_dbus, 32'd0);
        check("rst_drop_state", 32'(fsm_state), 32'd0);
        select = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        v = mk_bus(A_STAT, 1, 0, 0, 0, 1, 0);
        model_step(v, e_ack, e_data);
        apply_check("post_rst_stat", v, 1'b1, 32'h00000004);
        v = mk_bus(A_DATA, 1, 0, 0, 0, 1, 0);
        model_step(v, e_ack, e_data);
        apply_check("post_rst_data", v, 1'b1, 32'h0);

        check("tied_outputs", {29'd0, sl_err_ack, sl_retry, sl_tout_sup}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
